// File: rtl/ifu_fetch.sv
// ifu_fetch -- instruction fetch unit for the multi-cycle NPC core.
//
// Owns the architectural PC, fetches one instruction at a time from
// instruction memory and holds it for decode. The next PC always comes
// from the branch/next-PC generator; this block never increments the PC.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr   fetch request (addr == pc)
//   imem_rsp_valid, imem_rdata    8-byte-aligned doubleword response
//   inst_valid/ready, inst, pc    instruction handed to decode
//   next_pc_valid, next_pc        next PC from the generator
//   fetch_fault                   misaligned next-PC trap
//
// Optional feature: define IFU_MISALIGN_CHECK_EN to trap a next_pc with
// bit 1 set (enters S_FAULT until reset). Without it, next_pc[1:0] is
// simply cleared and fetch_fault is tied low.

module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [63:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] pc,
  input  logic        next_pc_valid,
  input  logic [63:0] next_pc,
  output logic        fetch_fault
);

  localparam logic [2:0] S_REQ   = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
`ifdef IFU_MISALIGN_CHECK_EN
  localparam logic [2:0] S_FAULT = 3'd4;
`endif

  logic [2:0]  state_q, state_d;
  logic [63:0] pc_q;
  logic [31:0] inst_q;
  logic        npc_misalign;

  // Low bits of next_pc are discarded by design (bit 0 is cleared
  // upstream; bit 1 only matters when the misalign check is built).
  logic unused_npc_lsbs;
  assign unused_npc_lsbs = ^next_pc[1:0];

`ifdef IFU_MISALIGN_CHECK_EN
  assign npc_misalign = next_pc[1];
`else
  assign npc_misalign = 1'b0;
`endif

  // Next-state logic. Inputs not relevant to the current state are
  // ignored, which is what makes spurious responses/next-PCs harmless.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:  if (imem_req_ready)  state_d = S_WAIT;
      S_WAIT: if (imem_rsp_valid)  state_d = S_HOLD;
      S_HOLD: if (inst_ready)      state_d = S_NEXT;
      S_NEXT: begin
        if (next_pc_valid) begin
`ifdef IFU_MISALIGN_CHECK_EN
          state_d = npc_misalign ? S_FAULT : S_REQ;
`else
          state_d = S_REQ;
`endif
        end
      end
`ifdef IFU_MISALIGN_CHECK_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      // Pick the 32-bit half of the doubleword selected by pc[2].
      if (state_q == S_WAIT && imem_rsp_valid)
        inst_q <= pc_q[2] ? imem_rdata[63:32] : imem_rdata[31:0];
      // A trapped next-PC leaves pc pointing at the faulting instruction.
      if (state_q == S_NEXT && next_pc_valid && !npc_misalign)
        pc_q <= {next_pc[63:2], 2'b00};
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_addr      = pc_q;
  assign inst_valid     = (state_q == S_HOLD);
  assign inst           = inst_q;
  assign pc             = pc_q;

`ifdef IFU_MISALIGN_CHECK_EN
  assign fetch_fault    = (state_q == S_FAULT);
`else
  assign fetch_fault    = 1'b0;
`endif

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the multi-cycle NPC core. It owns the architectural PC register and issues fetches to instruction memory over a valid/ready request and valid response. It presents each fetched 32-bit instruction to decode with a valid/ready handshake. It consumes the next-PC value produced by the branch/next-PC generator at the end of each instruction, so it is the receiving end of the next-PC path.

## Interface
- `RESET_PC`, default 64'h8000_0000: PC value loaded on reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_addr`  out  64  fetch address, equal to `pc`.
- `imem_rsp_valid`  in  1  read data valid.
- `imem_rdata`  in  64  8-byte-aligned doubleword containing the instruction.
- `inst_valid`  out  1  instruction held for decode.
- `inst_ready`  in  1  decode accepts the instruction.
- `inst`  out  32  fetched instruction.
- `pc`  out  64  PC of the current instruction.
- `next_pc_valid`  in  1  next-PC from the generator is valid.
- `next_pc`  in  64  next PC, bit 0 already cleared by the generator.
- `fetch_fault`  out  1  misaligned next-PC trap. Only active with `IFU_MISALIGN_CHECK_EN`; otherwise tied to 0.

## Operation
- FSM states: S_REQ, S_WAIT, S_HOLD, S_NEXT, S_FAULT. Encode in 3 bits.
- S_REQ:
  - `imem_req_valid`=1.
  - On `imem_req_valid & imem_req_ready`, go to S_WAIT.
  - `imem_addr` is stable while in S_REQ.
- S_WAIT:
  - On `imem_rsp_valid`, capture the instruction and go to S_HOLD.
  - Instruction = `pc[2]` ? `imem_rdata[63:32]` : `imem_rdata[31:0]`.
  - `imem_rsp_valid` is ignored in every state other than S_WAIT.
- S_HOLD:
  - `inst_valid`=1; `inst` and `pc` are stable.
  - On `inst_valid & inst_ready`, go to S_NEXT.
- S_NEXT:
  - Wait for `next_pc_valid`.
  - When it arrives, `pc` <= `next_pc` with bits [1:0] forced to 00, and go to S_REQ.
  - `next_pc_valid` is ignored outside S_NEXT.
- S_FAULT: exists only with the macro (see Configuration). The block stays here until `rst`.
- Arithmetic: the PC is only loaded, never incremented. All PC sequencing comes from `next_pc`.

## Timing
- Reset values:
  - state=S_REQ, `pc`=`RESET_PC`, `inst`=32'h0.
  - `inst_valid`=0, `fetch_fault`=0.
  - `imem_req_valid`=1 in the first cycle after `rst` deasserts.
- `rst` asserted in any state, including mid-request or mid-wait:
  - Return to S_REQ with the reset values.
  - A memory response arriving after reset is not in S_WAIT and is dropped.
- Request handshake with `imem_req_ready` already high: S_WAIT is entered on the next edge.
- Response timing:
  - A response is accepted no earlier than the cycle after the request handshake.
  - `inst_valid` rises the cycle after `imem_rsp_valid` is sampled in S_WAIT.
- Decode handshake: `inst_valid` drops the cycle after the handshake.
- Next-PC update:
  - `next_pc_valid` in S_NEXT updates `pc` at that edge.
  - A new `imem_req_valid` is issued in the following cycle.
- Minimum loop with all inputs ready: 4 cycles per instruction (REQ, WAIT, HOLD, NEXT).
- Backpressure: `imem_req_ready`=0, no response, and `inst_ready`=0 each stall the FSM indefinitely with all outputs held.

## Configuration
- `IFU_MISALIGN_CHECK_EN` defined:
  - In S_NEXT, `next_pc_valid` with `next_pc[1]`=1 leaves `pc` unchanged.
  - Go to S_FAULT with `fetch_fault`=1 held.
  - In S_FAULT: no requests, `inst_valid`=0, all inputs ignored until `rst`.
- `IFU_MISALIGN_CHECK_EN` undefined:
  - `next_pc[1:0]` is silently cleared.
  - S_FAULT is not generated and `fetch_fault` is tied to 0.

## Test plan
- Reset then `imem_req_ready`=1 and a response 1 cycle later with `imem_rdata`=64'h00100093_00000013 → `imem_addr`=0x80000000, `inst`=32'h00000013 and `inst_valid`=1 in cycle 3.
- In S_NEXT, `next_pc`=0x80000004 → next request has `imem_addr`=0x80000004; a response with the same rdata gives `inst`=32'h00100093 (upper half).
- Backpressure: `imem_req_ready` low 5 cycles, response delayed 3 cycles, `inst_ready` low 4 cycles → outputs stable throughout; instruction delivered exactly once.
- A spurious `imem_rsp_valid` during S_REQ or S_HOLD, and `next_pc_valid` during S_HOLD → ignored; `pc` and `inst` unchanged.
- `rst` pulsed while in S_WAIT, followed by a late response → `pc`=0x80000000, `inst_valid`=0, new request issued; the late response is dropped.
- `next_pc`=0x80000006:
  - With the macro: `fetch_fault`=1, `pc` unchanged, no further requests until `rst`.
  - Without the macro: next fetch at 0x80000004.
